// File: rtl/dsp_mac_pkg.sv
// Shared definitions for the dsp_mac_pipe block.
// Holds the OPMODE bit positions and the clamp/overflow helper.
// Contents: OP_* bit indices, wide_t scratch type, sat_wrap().
package dsp_mac_pkg;

  // OPMODE bit positions
  localparam int OP_PRE_EN  = 0;  // enable pre-adder
  localparam int OP_PRE_SUB = 1;  // pre-adder computes D-A instead of D+A
  localparam int OP_ACC     = 2;  // 1 = accumulate onto channel, 0 = load
  localparam int OP_PSUB    = 3;  // subtract product from base

  // Scratch width for accumulator arithmetic; must exceed ACC_W+1.
  localparam int MAX_W = 128;
  typedef logic signed [MAX_W-1:0] wide_t;

  // sum carries a w+1 bit signed value, sign-extended to MAX_W.
  // ovf flags that it does not fit in w bits. With sat_en the value
  // is clamped to the w-bit max/min; otherwise the caller keeps the
  // low w bits, which is the two's-complement wrap.
  function automatic wide_t sat_wrap(input wide_t sum, input int w,
                                     input logic sat_en, output logic ovf);
    wide_t upper;
    wide_t max_pos;
    wide_t res;
    upper   = sum >>> (w - 1);
    ovf     = (upper != '0) && (upper != '1);
    max_pos = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    res     = sum;
    if (ovf && sat_en) begin
      res = sum[MAX_W-1] ? ~max_pos : max_pos;
    end
    return res;
  endfunction

endpackage

// File: rtl/dsp_acc_bank.sv
// Accumulator bank: NUM_CH accumulators with sticky overflow flags and
// the S3 add/subtract/saturate datapath. Result is combinational from
// the registered bank; the bank updates only when upd_vld is high.
// Ports: clk/rst, upd_vld, ch, op_acc, op_sub, last, prod in; res, res_ovf out.
module dsp_acc_bank
  import dsp_mac_pkg::*;
#(
  parameter int ACC_W  = 48,
  parameter int NUM_CH = 4,
  parameter int SAT_EN = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      upd_vld,
  input  logic [$clog2(NUM_CH)-1:0] ch,
  input  logic                      op_acc,
  input  logic                      op_sub,
  input  logic                      last,
  input  logic signed [ACC_W-1:0]   prod,
  output logic signed [ACC_W-1:0]   res,
  output logic                      res_ovf
);

  logic signed [ACC_W-1:0] acc_q [NUM_CH];
  logic signed [ACC_W-1:0] acc_d [NUM_CH];
  logic [NUM_CH-1:0]       ovf_q;
  logic [NUM_CH-1:0]       ovf_d;

  logic signed [ACC_W-1:0] base;
  logic                    base_ovf;
  wide_t                   sum;
  wide_t                   res_w;
  logic                    sum_ovf;

  always_comb begin
    base     = op_acc ? acc_q[ch] : '0;
    // a load starts the channel afresh, so its old flag is dropped too
    base_ovf = op_acc & ovf_q[ch];
    sum      = op_sub ? (wide_t'(base) - wide_t'(prod))
                      : (wide_t'(base) + wide_t'(prod));
    res_w    = sat_wrap(sum, ACC_W, SAT_EN != 0, sum_ovf);
    res      = res_w[ACC_W-1:0];
    res_ovf  = base_ovf | sum_ovf;

    acc_d = acc_q;
    ovf_d = ovf_q;
    if (upd_vld) begin
      // an emitted channel is cleared so the next sample starts from zero
      acc_d[ch] = last ? '0 : res;
      ovf_d[ch] = last ? 1'b0 : res_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Pre-add / multiply / accumulate pipeline with NUM_CH channel accumulators.
// Latency 3 cycles accepted-input to OUT_VALID; full throughput, no bubbles.
// Backpressure: whole pipe stalls while OUT_VALID && !OUT_READY (IN_READY low).
// Ports: IN_VALID/IN_READY + A, D, B, CH, OPMODE, LAST in; OUT_VALID/OUT_READY + P, P_CH, OVF out.
module dsp_mac_pipe
  import dsp_mac_pkg::*;
#(
  parameter int A_W    = 18,
  parameter int B_W    = 18,
  parameter int ACC_W  = 48,
  parameter int NUM_CH = 4,
  parameter int SAT_EN = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic signed [A_W-1:0]     A,
  input  logic signed [A_W-1:0]     D,
  input  logic signed [B_W-1:0]     B,
  input  logic [$clog2(NUM_CH)-1:0] CH,
  input  logic [3:0]                OPMODE,
  input  logic                      LAST,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic signed [ACC_W-1:0]   P,
  output logic [$clog2(NUM_CH)-1:0] P_CH,
  output logic                      OVF
);

  localparam int CW  = $clog2(NUM_CH);
  localparam int PAW = A_W + 1;        // pre-adder width
  localparam int PW  = A_W + 1 + B_W;  // full-precision product width

  logic adv;  // every stage moves this cycle

  // S1: registered inputs
  logic                  s1_vld_q, s1_vld_d;
  logic signed [A_W-1:0] s1_a_q, s1_a_d, s1_d_q, s1_d_d;
  logic signed [B_W-1:0] s1_b_q, s1_b_d;
  logic [CW-1:0]         s1_ch_q, s1_ch_d;
  logic [3:0]            s1_op_q, s1_op_d;
  logic                  s1_last_q, s1_last_d;

  // S2: registered product plus the control S3 needs
  logic                  s2_vld_q, s2_vld_d;
  logic signed [PW-1:0]  s2_prod_q, s2_prod_d;
  logic [CW-1:0]         s2_ch_q, s2_ch_d;
  logic                  s2_acc_q, s2_acc_d;
  logic                  s2_sub_q, s2_sub_d;
  logic                  s2_last_q, s2_last_d;

  // S3 output register
  logic                    out_vld_q, out_vld_d;
  logic signed [ACC_W-1:0] p_q, p_d;
  logic [CW-1:0]           p_ch_q, p_ch_d;
  logic                    ovf_out_q, ovf_out_d;

  logic signed [PAW-1:0]   a_ext, d_ext, pre;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bank_res;
  logic                    bank_ovf;
  logic                    emit;

  assign adv      = !(out_vld_q && !OUT_READY);
  assign IN_READY = adv;
  assign prod_ext = ACC_W'(s2_prod_q);
  assign emit     = s2_vld_q && s2_last_q;

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_a_d    = s1_a_q;
    s1_d_d    = s1_d_q;
    s1_b_d    = s1_b_q;
    s1_ch_d   = s1_ch_q;
    s1_op_d   = s1_op_q;
    s1_last_d = s1_last_q;
    if (adv) begin
      s1_vld_d  = IN_VALID;
      s1_a_d    = A;
      s1_d_d    = D;
      s1_b_d    = B;
      s1_ch_d   = CH;
      s1_op_d   = OPMODE;
      s1_last_d = LAST;
    end
  end

  always_comb begin
    a_ext = PAW'(s1_a_q);
    d_ext = PAW'(s1_d_q);
    if (!s1_op_q[OP_PRE_EN])      pre = a_ext;
    else if (s1_op_q[OP_PRE_SUB]) pre = d_ext - a_ext;
    else                          pre = d_ext + a_ext;

    s2_vld_d  = s2_vld_q;
    s2_prod_d = s2_prod_q;
    s2_ch_d   = s2_ch_q;
    s2_acc_d  = s2_acc_q;
    s2_sub_d  = s2_sub_q;
    s2_last_d = s2_last_q;
    if (adv) begin
      s2_vld_d  = s1_vld_q;
      s2_prod_d = PW'(pre) * PW'(s1_b_q);
      s2_ch_d   = s1_ch_q;
      s2_acc_d  = s1_op_q[OP_ACC];
      s2_sub_d  = s1_op_q[OP_PSUB];
      s2_last_d = s1_last_q;
    end
  end

  // S3 is the only reader/writer of the bank, so back-to-back samples
  // to one channel see each other's result without forwarding.
  dsp_acc_bank #(
    .ACC_W  (ACC_W),
    .NUM_CH (NUM_CH),
    .SAT_EN (SAT_EN)
  ) u_bank (
    .clk     (CLK),
    .rst     (RST),
    .upd_vld (s2_vld_q && adv),
    .ch      (s2_ch_q),
    .op_acc  (s2_acc_q),
    .op_sub  (s2_sub_q),
    .last    (s2_last_q),
    .prod    (prod_ext),
    .res     (bank_res),
    .res_ovf (bank_ovf)
  );

  always_comb begin
    out_vld_d = out_vld_q;
    p_d       = p_q;
    p_ch_d    = p_ch_q;
    ovf_out_d = ovf_out_q;
    if (adv) begin
      // adv means the held result (if any) is consumed this cycle
      out_vld_d = emit;
      if (emit) begin
        p_d       = bank_res;
        p_ch_d    = s2_ch_q;
        ovf_out_d = bank_ovf;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_d_q    <= '0;
      s1_b_q    <= '0;
      s1_ch_q   <= '0;
      s1_op_q   <= '0;
      s1_last_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_prod_q <= '0;
      s2_ch_q   <= '0;
      s2_acc_q  <= 1'b0;
      s2_sub_q  <= 1'b0;
      s2_last_q <= 1'b0;
      out_vld_q <= 1'b0;
      p_q       <= '0;
      p_ch_q    <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_a_q    <= s1_a_d;
      s1_d_q    <= s1_d_d;
      s1_b_q    <= s1_b_d;
      s1_ch_q   <= s1_ch_d;
      s1_op_q   <= s1_op_d;
      s1_last_q <= s1_last_d;
      s2_vld_q  <= s2_vld_d;
      s2_prod_q <= s2_prod_d;
      s2_ch_q   <= s2_ch_d;
      s2_acc_q  <= s2_acc_d;
      s2_sub_q  <= s2_sub_d;
      s2_last_q <= s2_last_d;
      out_vld_q <= out_vld_d;
      p_q       <= p_d;
      p_ch_q    <= p_ch_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign OUT_VALID = out_vld_q;
  assign P         = p_q;
  assign P_CH      = p_ch_q;
  assign OVF       = ovf_out_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Testbench for dsp_mac_pipe (ACC_W=40 so saturation is reachable quickly).
// Directed scenarios plus randomized traffic against a per-channel integer model.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_dsp_mac_pipe;

  localparam int A_W    = 18;
  localparam int B_W    = 18;
  localparam int ACC_W  = 40;
  localparam int NUM_CH = 4;
  localparam int SAT_EN = 1;
  localparam int CW     = 2;

  localparam longint MAXV = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< (ACC_W - 1));

  logic                  CLK = 1'b0;
  logic                  RST;
  logic                  IN_VALID;
  logic                  IN_READY;
  logic signed [A_W-1:0] A, D;
  logic signed [B_W-1:0] B;
  logic [CW-1:0]         CH;
  logic [3:0]            OPMODE;
  logic                  LAST;
  logic                  OUT_VALID;
  logic                  OUT_READY;
  logic signed [ACC_W-1:0] P;
  logic [CW-1:0]         P_CH;
  logic                  OVF;

  dsp_mac_pipe #(
    .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .NUM_CH(NUM_CH), .SAT_EN(SAT_EN)
  ) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .D(D), .B(B), .CH(CH), .OPMODE(OPMODE), .LAST(LAST),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .P(P), .P_CH(P_CH), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    longint p;
    int     ch;
    bit     ovf;
    int     cyc;
  } res_t;

  res_t   got_q[$];
  res_t   exp_q[$];
  longint macc[NUM_CH];
  bit     mflag[NUM_CH];
  int     cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;
  bit     rand_done;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model: applies each accepted sample to a per-channel integer
  // accumulator in acceptance order.
  always @(negedge CLK) begin
    if (!RST && IN_VALID && IN_READY) begin
      longint av, dv, bv, pre, prod, base, r;
      bit     fl, ov;
      int     c;
      av = longint'(A);
      dv = longint'(D);
      bv = longint'(B);
      c  = int'(CH);
      if (!OPMODE[0])     pre = av;
      else if (OPMODE[1]) pre = dv - av;
      else                pre = dv + av;
      prod = pre * bv;
      base = OPMODE[2] ? macc[c] : 64'sd0;
      fl   = OPMODE[2] ? mflag[c] : 1'b0;
      r    = OPMODE[3] ? base - prod : base + prod;
      ov   = (r > MAXV) || (r < MINV);
      if (ov) begin
        if (SAT_EN != 0) r = (r > MAXV) ? MAXV : MINV;
        else if (r > MAXV) r = r - (64'sd1 <<< ACC_W);
        else r = r + (64'sd1 <<< ACC_W);
      end
      fl = fl | ov;
      if (LAST) begin
        res_t e;
        e.p = r; e.ch = c; e.ovf = fl; e.cyc = 0;
        exp_q.push_back(e);
        macc[c]  = 0;
        mflag[c] = 1'b0;
      end else begin
        macc[c]  = r;
        mflag[c] = fl;
      end
    end
  end

  // Collect every delivered result.
  always @(negedge CLK) begin
    if (!RST && OUT_VALID && OUT_READY) begin
      res_t g;
      g.p = longint'(P); g.ch = int'(P_CH); g.ovf = OVF; g.cyc = cyc;
      got_q.push_back(g);
    end
  end

  task automatic model_clear();
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < NUM_CH; i++) begin
      macc[i]  = 0;
      mflag[i] = 1'b0;
    end
  endtask

  // Present one sample and hold it until accepted. Entered between a rising
  // edge and the next falling edge; returns 1 unit after the accepting edge.
  task automatic send(input longint a, input longint d, input longint b, input int ch,
                      input logic [3:0] op, input bit last, output int acc_cyc);
    int n;
    n = 0;
    A = A_W'(a); D = A_W'(d); B = B_W'(b); CH = CW'(ch);
    OPMODE = op; LAST = last; IN_VALID = 1'b1;
    @(negedge CLK);
    while (!IN_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    acc_cyc = cyc;
    if (!IN_READY) begin
      vectors++; miscompares++;
      $display("FAIL send_accept in_ready=%b required=1 after %0d cycles", IN_READY, n);
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic wait_got(input int n, output bit ok);
    int k;
    k = 0;
    while (got_q.size() < n && k < 200) begin
      @(posedge CLK); #1;
      k++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    vectors++; if (IN_READY !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got=%b required=1", IN_READY); end
    vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got=%b required=0", OUT_VALID); end
    vectors++; if (P !== '0) begin miscompares++; $display("FAIL rst_p got=%0d required=0", P); end
    vectors++; if (P_CH !== '0) begin miscompares++; $display("FAIL rst_p_ch got=%0d required=0", P_CH); end
    vectors++; if (OVF !== 1'b0) begin miscompares++; $display("FAIL rst_ovf got=%b required=0", OVF); end
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_midstream();
    int c0, c1;
    bit ok;
    res_t g;
    model_clear();
    send(100, 0, 100, 1, 4'b0100, 1'b0, c0);
    send(2, 0, 2, 3, 4'b0000, 1'b1, c0);
    send(3, 0, 3, 3, 4'b0000, 1'b1, c0);
    send(4, 0, 4, 3, 4'b0000, 1'b1, c0);
    vectors++; if (OUT_VALID !== 1'b1 || P !== 40'sd4) begin miscompares++; $display("FAIL pre_rst_out valid=%b p=%0d required valid=1 p=4", OUT_VALID, P); end
    #1 RST = 1'b1;
    #1;
    vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid got=%b required=0", OUT_VALID); end
    vectors++; if (P !== '0) begin miscompares++; $display("FAIL midrst_p got=%0d required=0", P); end
    vectors++; if (IN_READY !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready got=%b required=1", IN_READY); end
    model_clear();
    @(posedge CLK); #1;
    RST = 1'b0;
    send(2, 0, 3, 0, 4'b0000, 1'b1, c0);
    send(1, 0, 1, 1, 4'b0100, 1'b1, c1);
    wait_got(2, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL postrst_results got=%0d required=2", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g.p !== 6 || g.ch !== 0) begin miscompares++; $display("FAIL postrst_load p=%0d ch=%0d required p=6 ch=0", g.p, g.ch); end
      vectors++; if (g.cyc !== c0 + 3) begin miscompares++; $display("FAIL postrst_latency got=%0d required=3", g.cyc - c0); end
      g = got_q.pop_front();
      vectors++; if (g.p !== 1 || g.ch !== 1) begin miscompares++; $display("FAIL postrst_zeroed p=%0d ch=%0d required p=1 ch=1", g.p, g.ch); end
    end
  endtask

  task automatic test_preadd();
    int c;
    bit ok;
    res_t g;
    model_clear();
    send(5, 7, 3, 0, 4'b0011, 1'b1, c);
    send(5, 7, 3, 0, 4'b0001, 1'b1, c);
    wait_got(2, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL preadd_results got=%0d required=2", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g.p !== 6) begin miscompares++; $display("FAIL preadd_sub got=%0d required=6", g.p); end
      g = got_q.pop_front();
      vectors++; if (g.p !== 36) begin miscompares++; $display("FAIL preadd_add got=%0d required=36", g.p); end
    end
  endtask

  task automatic test_interleave();
    int c;
    bit ok;
    res_t g0, g1;
    model_clear();
    for (int i = 0; i < 8; i++)
      send(1, 0, (i % 2) + 1, i % 2, 4'b0100, i >= 6, c);
    wait_got(2, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL interleave_results got=%0d required=2", got_q.size());
    end else begin
      g0 = got_q.pop_front();
      g1 = got_q.pop_front();
      if (g0.p !== 4 || g0.ch !== 0) begin miscompares++; $display("FAIL interleave_ch0 p=%0d ch=%0d required p=4 ch=0", g0.p, g0.ch); end
      vectors++; if (g1.p !== 8 || g1.ch !== 1) begin miscompares++; $display("FAIL interleave_ch1 p=%0d ch=%0d required p=8 ch=1", g1.p, g1.ch); end
      vectors++; if (g1.cyc !== g0.cyc + 1) begin miscompares++; $display("FAIL interleave_gap got=%0d required=1", g1.cyc - g0.cyc); end
    end
  endtask

  task automatic test_saturation();
    int c;
    bit ok;
    res_t g;
    model_clear();
    for (int i = 0; i < 40; i++)
      send(131071, 0, 131071, 2, 4'b0100, i == 39, c);
    send(1, 0, 1, 2, 4'b0000, 1'b1, c);
    wait_got(2, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL sat_results got=%0d required=2", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g.p !== 64'sd549755813887 || g.ch !== 2) begin miscompares++; $display("FAIL sat_clamp p=%0d ch=%0d required p=549755813887 ch=2", g.p, g.ch); end
      vectors++; if (g.ovf !== 1'b1) begin miscompares++; $display("FAIL sat_ovf got=%b required=1", g.ovf); end
      g = got_q.pop_front();
      vectors++; if (g.p !== 1 || g.ovf !== 1'b0) begin miscompares++; $display("FAIL sat_reload p=%0d ovf=%b required p=1 ovf=0", g.p, g.ovf); end
    end
  endtask

  task automatic test_subtract();
    int c;
    bit ok;
    res_t g;
    model_clear();
    send(10, 0, 10, 3, 4'b0000, 1'b0, c);
    send(3, 0, 4, 3, 4'b1100, 1'b1, c);
    wait_got(1, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL sub_results got=%0d required=1", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g.p !== 88 || g.ch !== 3) begin miscompares++; $display("FAIL sub_value p=%0d ch=%0d required p=88 ch=3", g.p, g.ch); end
    end
  endtask

  task automatic test_backpressure();
    int c;
    bit ok;
    res_t g;
    model_clear();
    OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++)
      send(i + 2, 0, 5, i, 4'b0000, 1'b1, c);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      vectors++; if (IN_READY !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready cyc%0d got=%b required=0", k, IN_READY); end
      vectors++; if (OUT_VALID !== 1'b1 || P !== 40'sd10) begin miscompares++; $display("FAIL bp_hold cyc%0d valid=%b p=%0d required valid=1 p=10", k, OUT_VALID, P); end
    end
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    wait_got(3, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL bp_results got=%0d required=3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        g = got_q.pop_front();
        if (i > 0) vectors++;
        if (g.p !== 5 * (i + 2) || g.ch !== i) begin miscompares++; $display("FAIL bp_order idx%0d p=%0d ch=%0d required p=%0d ch=%0d", i, g.p, g.ch, 5 * (i + 2), i); end
      end
      vectors++; if (got_q.size() !== 0) begin miscompares++; $display("FAIL bp_extra got=%0d required=0", got_q.size()); end
    end
  endtask

  task automatic test_random();
    int n;
    res_t g, e;
    model_clear();
    rand_done = 1'b0;
    fork
      begin
        int c;
        for (int i = 0; i < 300; i++)
          send(longint'($urandom), longint'($urandom), longint'($urandom),
               int'($urandom_range(0, NUM_CH - 1)), 4'($urandom_range(0, 15)),
               $urandom_range(0, 3) == 0, c);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          OUT_READY = ($urandom_range(0, 2) != 0);
          @(posedge CLK); #1;
        end
      end
    join
    OUT_READY = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL rand_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (g.p !== e.p || g.ch !== e.ch || g.ovf !== e.ovf) begin
        miscompares++;
        $display("FAIL rand_result idx%0d got p=%0d ch=%0d ovf=%b required p=%0d ch=%0d ovf=%b",
                 i, g.p, g.ch, g.ovf, e.p, e.ch, e.ovf);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    A = '0; D = '0; B = '0; CH = '0; OPMODE = '0; LAST = 1'b0;
    model_clear();
    test_reset();
    test_reset_midstream();
    test_preadd();
    test_interleave();
    test_saturation();
    test_subtract();
    test_backpressure();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
